// File: rtl/vector_div_issue_if.sv
// Issue/result handshake between the vector lane divide sequencer (master) and the divide unit (slave).
interface vector_div_issue_if #(
  parameter int unsigned ELEN = 32
);
  logic            start_div;
  logic [ELEN-1:0] div_vs1;
  logic [ELEN-1:0] div_vs2;
  logic            div_type;
  logic            is_signed_div;
  logic            busy_du;
  logic            done_du;
  logic [ELEN-1:0] wdata_du;
  logic            exception_du;

  modport master (
    output start_div, div_vs1, div_vs2, div_type, is_signed_div,
    input  busy_du, done_du, wdata_du, exception_du
  );

  modport slave (
    input  start_div, div_vs1, div_vs2, div_type, is_signed_div,
    output busy_du, done_du, wdata_du, exception_du
  );
endinterface

// File: rtl/vector_div_issue.sv
// Sequences one vector divide op element-by-element onto the lane divide unit and writes results back.
// Optional macro VDIV_ZERO_BYPASS_EN: active divide-by-zero elements skip the unit and write back directly.
module vector_div_issue #(
  parameter int unsigned VLMAX = 32,
  parameter int unsigned ELEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [$clog2(VLMAX):0]   req_vl,
  input  logic                     req_div_type,
  input  logic                     req_is_signed,
  input  logic                     req_vm,
  input  logic                     kill,
  output logic [$clog2(VLMAX)-1:0] rd_idx,
  input  logic [ELEN-1:0]          rd_vs1,
  input  logic [ELEN-1:0]          rd_vs2,
  input  logic                     rd_mask,
  vector_div_issue_if.master       du,
  output logic                     wb_valid,
  output logic [$clog2(VLMAX)-1:0] wb_idx,
  output logic [ELEN-1:0]          wb_data,
  output logic                     done,
  output logic                     exception
);
  localparam int unsigned IDX_W = $clog2(VLMAX);
  localparam int unsigned VL_W  = IDX_W + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_DRAIN = 3'd6;

  logic [2:0]      state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [VL_W-1:0] vl_q, vl_nxt;
  logic            vm_q, vm_nxt;
  logic            type_nxt, signed_nxt, start_nxt, ready_nxt;
  logic            wb_valid_nxt, done_nxt, exc_nxt;
  logic [ELEN-1:0] vs1_nxt, vs2_nxt, wb_data_nxt;
  logic [IDX_W-1:0] wb_idx_nxt;
  logic            last;
  logic            active;

  // Operand read port always addresses the current element; the register file answers same-cycle.
  assign rd_idx = idx;
  assign last   = (VL_W'(idx) + VL_W'(1)) == vl_q;
  assign active = vm_q || rd_mask;

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    vl_nxt       = vl_q;
    vm_nxt       = vm_q;
    type_nxt     = du.div_type;
    signed_nxt   = du.is_signed_div;
    vs1_nxt      = du.div_vs1;
    vs2_nxt      = du.div_vs2;
    start_nxt    = 1'b0;
    wb_valid_nxt = 1'b0;
    wb_idx_nxt   = wb_idx;
    wb_data_nxt  = wb_data;
    done_nxt     = 1'b0;
    exc_nxt      = exception;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          vl_nxt     = req_vl;
          vm_nxt     = req_vm;
          type_nxt   = req_div_type;
          signed_nxt = req_is_signed;
          exc_nxt    = 1'b0;
          idx_nxt    = '0;
          if (req_vl == '0) begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (kill) begin
          state_nxt = S_IDLE;
        end else if (!active) begin
          // Masked-off element: destination left undisturbed, costs one cycle.
          if (last) begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end else begin
          vs1_nxt = rd_vs1;
          vs2_nxt = rd_vs2;
`ifdef VDIV_ZERO_BYPASS_EN
          if (rd_vs1 == '0) begin
            state_nxt    = S_WB;
            wb_valid_nxt = 1'b1;
            wb_idx_nxt   = idx;
            wb_data_nxt  = du.div_type ? rd_vs2 : '1;
          end else begin
            state_nxt = S_ISSUE;
          end
`else
          state_nxt = S_ISSUE;
`endif
        end
      end
      S_ISSUE: begin
        if (kill) begin
          state_nxt = S_IDLE;
        end else if (!du.busy_du) begin
          start_nxt = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // A kill once the unit has the op must wait for its result before going idle.
        if (du.done_du) begin
          if (kill) begin
            state_nxt = S_IDLE;
          end else begin
            exc_nxt      = exception | du.exception_du;
            wb_valid_nxt = 1'b1;
            wb_idx_nxt   = idx;
            wb_data_nxt  = du.wdata_du;
            state_nxt    = S_WB;
          end
        end else if (kill) begin
          state_nxt = S_DRAIN;
        end
      end
      S_WB: begin
        if (kill) begin
          state_nxt = S_IDLE;
        end else if (last) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
        end else begin
          idx_nxt   = idx + IDX_W'(1);
          state_nxt = S_FETCH;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      S_DRAIN: if (du.done_du) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    ready_nxt = (state_nxt == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      idx              <= '0;
      vl_q             <= '0;
      vm_q             <= 1'b0;
      req_ready        <= 1'b1;
      du.start_div     <= 1'b0;
      du.div_vs1       <= '0;
      du.div_vs2       <= '0;
      du.div_type      <= 1'b0;
      du.is_signed_div <= 1'b0;
      wb_valid         <= 1'b0;
      wb_idx           <= '0;
      wb_data          <= '0;
      done             <= 1'b0;
      exception        <= 1'b0;
    end else begin
      state            <= state_nxt;
      idx              <= idx_nxt;
      vl_q             <= vl_nxt;
      vm_q             <= vm_nxt;
      req_ready        <= ready_nxt;
      du.start_div     <= start_nxt;
      du.div_vs1       <= vs1_nxt;
      du.div_vs2       <= vs2_nxt;
      du.div_type      <= type_nxt;
      du.is_signed_div <= signed_nxt;
      wb_valid         <= wb_valid_nxt;
      wb_idx           <= wb_idx_nxt;
      wb_data          <= wb_data_nxt;
      done             <= done_nxt;
      exception        <= exc_nxt;
    end
  end
endmodule

// File: tb/tb_vector_div_issue.sv
// Directed self-checking bench for vector_div_issue with a behavioural divide unit and operand file.
`timescale 1ns/1ps
module tb_vector_div_issue;
  localparam int unsigned VLMAX = 32;
  localparam int unsigned ELEN  = 32;
  localparam int unsigned IDX_W = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             req_valid, req_ready, req_div_type, req_is_signed, req_vm, kill;
  logic [IDX_W:0]   req_vl;
  logic [IDX_W-1:0] rd_idx, wb_idx;
  logic [ELEN-1:0]  rd_vs1, rd_vs2, wb_data;
  logic             rd_mask, wb_valid, done, exception;

  vector_div_issue_if #(.ELEN(ELEN)) du ();

  vector_div_issue #(.VLMAX(VLMAX), .ELEN(ELEN)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_vl(req_vl),
    .req_div_type(req_div_type), .req_is_signed(req_is_signed), .req_vm(req_vm),
    .kill(kill), .rd_idx(rd_idx), .rd_vs1(rd_vs1), .rd_vs2(rd_vs2), .rd_mask(rd_mask),
    .du(du), .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data),
    .done(done), .exception(exception)
  );

  // Operand file: vs2[i] = base + i, vs1 constant, v0 from a mask word.
  logic [31:0] cur_vs1, cur_base, cur_mask;
  assign rd_vs1  = cur_vs1;
  assign rd_vs2  = cur_base + 32'(rd_idx);
  assign rd_mask = cur_mask[rd_idx];

  // Behavioural divide unit with programmable latency.
  int unsigned du_lat;
  int          du_cnt;
  logic [31:0] op1, op2;
  logic        op_type, op_sgn, busy_force;
  assign du.busy_du = busy_force;

  function automatic logic [32:0] div_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic typ, input logic sgn);
    logic [31:0] r;
    if (b == 32'd0) return {1'b1, (typ ? a : 32'hFFFF_FFFF)};
    if (sgn) r = typ ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    else     r = typ ? (a % b) : (a / b);
    return {1'b0, r};
  endfunction

  always @(posedge clk) begin
    du.done_du      <= 1'b0;
    du.exception_du <= 1'b0;
    if (rst) begin
      du_cnt      <= 0;
      du.wdata_du <= 32'd0;
    end else if (du.start_div) begin
      op1 <= du.div_vs1; op2 <= du.div_vs2; op_type <= du.div_type; op_sgn <= du.is_signed_div;
      if (du_lat <= 1) begin
        du.done_du <= 1'b1;
        {du.exception_du, du.wdata_du} <= div_model(du.div_vs2, du.div_vs1, du.div_type, du.is_signed_div);
      end else begin
        du_cnt <= int'(du_lat) - 1;
      end
    end else if (du_cnt > 0) begin
      du_cnt <= du_cnt - 1;
      if (du_cnt == 1) begin
        du.done_du <= 1'b1;
        {du.exception_du, du.wdata_du} <= div_model(op2, op1, op_type, op_sgn);
      end
    end
  end

  // Monitor: logs pulses and write-backs away from the active edge.
  int cyc = 0;
  int n_start = 0, n_done = 0;
  int start_c[$], wb_c[$], wb_i_q[$];
  logic [31:0] wb_d_q[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (du.start_div === 1'b1) begin n_start = n_start + 1; start_c.push_back(cyc); end
    if (wb_valid === 1'b1) begin wb_c.push_back(cyc); wb_i_q.push_back(int'(wb_idx)); wb_d_q.push_back(wb_data); end
    if (done === 1'b1) n_done = n_done + 1;
  end

  int checks = 0, errors = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    int              vl;
    logic            vm;
    logic [31:0]     mask;
    logic            typ;
    logic            sgn;
    logic [31:0]     vs1;
    logic [31:0]     base;
    int              lat;
    int              n_exp;
    logic [3:0][4:0] exp_idx;
    logic [3:0][31:0] exp_data;
    int              exp_start;
    logic            exp_exc;
  } vec_t;

  function automatic vec_t mkv(input int vl, input logic vm, input logic [31:0] mask,
                               input logic typ, input logic sgn, input logic [31:0] vs1,
                               input logic [31:0] base, input int lat, input int n,
                               input logic [19:0] idxs, input logic [127:0] data,
                               input int st, input logic exc);
    vec_t v;
    v.vl = vl; v.vm = vm; v.mask = mask; v.typ = typ; v.sgn = sgn; v.vs1 = vs1;
    v.base = base; v.lat = lat; v.n_exp = n; v.exp_idx = idxs; v.exp_data = data;
    v.exp_start = st; v.exp_exc = exc;
    return v;
  endfunction

  localparam int NV = 9;
  vec_t vecs [NV];

  task automatic start_req(input int vl, input logic vm, input logic typ, input logic sgn);
    req_valid = 1'b1; req_vl = (IDX_W+1)'(vl); req_vm = vm; req_div_type = typ; req_is_signed = sgn;
  endtask

  task automatic wait_done(input int d0, input string name);
    int t = 0;
    while (n_done == d0 && t < 2000) begin @(negedge clk); #1; t++; end
    check({name, "_done_seen"}, 64'(t < 2000), 64'd1);
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    int s0, sc0, w0, d0;
    string nm;
    v = vecs[k];
    nm = $sformatf("v%0d", k);
    cur_vs1 = v.vs1; cur_base = v.base; cur_mask = v.mask; du_lat = v.lat;
    @(negedge clk);
    s0 = n_start; sc0 = start_c.size(); w0 = wb_d_q.size(); d0 = n_done;
    start_req(v.vl, v.vm, v.typ, v.sgn);
    @(negedge clk); #1;
    req_valid = 1'b0;
    wait_done(d0, nm);
    repeat (3) @(negedge clk);
    #1;
    check({nm, "_wb_count"}, 64'(wb_d_q.size() - w0), 64'(v.n_exp));
    check({nm, "_start_count"}, 64'(n_start - s0), 64'(v.exp_start));
    check({nm, "_done_count"}, 64'(n_done - d0), 64'd1);
    check({nm, "_exception"}, 64'(exception), 64'(v.exp_exc));
    check({nm, "_ready_after"}, 64'(req_ready), 64'd1);
    for (int j = 0; j < v.n_exp && (w0 + j) < wb_d_q.size(); j++) begin
      check($sformatf("%s_wb%0d_idx", nm, j), 64'(wb_i_q[w0+j]), 64'(v.exp_idx[j]));
      check($sformatf("%s_wb%0d_data", nm, j), 64'(wb_d_q[w0+j]), 64'(v.exp_data[j]));
      if (v.exp_start == v.n_exp && (sc0 + j) < start_c.size())
        check($sformatf("%s_wb%0d_latency", nm, j), 64'(wb_c[w0+j] - start_c[sc0+j]), 64'(v.lat + 1));
    end
  endtask

  initial begin
    int a, s0, w0, d0, t;
    int zs2, zs1;
    logic ze;
`ifdef VDIV_ZERO_BYPASS_EN
    zs2 = 0; zs1 = 0; ze = 1'b0;
`else
    zs2 = 2; zs1 = 1; ze = 1'b1;
`endif
    vecs[0] = mkv(4, 1'b1, 32'h0, 1'b0, 1'b0, 32'd3, 32'd20, 5, 4,
                  {5'd3, 5'd2, 5'd1, 5'd0}, {32'd7, 32'd7, 32'd7, 32'd6}, 4, 1'b0);
    vecs[1] = mkv(4, 1'b0, 32'h5, 1'b1, 1'b0, 32'd3, 32'd20, 2, 2,
                  {5'd0, 5'd0, 5'd2, 5'd0}, {32'd0, 32'd0, 32'd1, 32'd2}, 2, 1'b0);
    vecs[2] = mkv(0, 1'b1, 32'h0, 1'b0, 1'b0, 32'd3, 32'd20, 2, 0, 20'd0, 128'd0, 0, 1'b0);
    vecs[3] = mkv(3, 1'b1, 32'h0, 1'b1, 1'b0, 32'd7, 32'd100, 1, 3,
                  {5'd0, 5'd2, 5'd1, 5'd0}, {32'd0, 32'd4, 32'd3, 32'd2}, 3, 1'b0);
    vecs[4] = mkv(3, 1'b1, 32'h0, 1'b0, 1'b1, 32'd4, 32'hFFFF_FFEC, 3, 3,
                  {5'd0, 5'd2, 5'd1, 5'd0},
                  {32'd0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFFB}, 3, 1'b0);
    vecs[5] = mkv(3, 1'b0, 32'h0, 1'b0, 1'b0, 32'd3, 32'd20, 2, 0, 20'd0, 128'd0, 0, 1'b0);
    vecs[6] = mkv(32, 1'b0, 32'h8000_0001, 1'b0, 1'b0, 32'd2, 32'd40, 2, 2,
                  {5'd0, 5'd0, 5'd31, 5'd0}, {32'd0, 32'd0, 32'd35, 32'd20}, 2, 1'b0);
    vecs[7] = mkv(2, 1'b1, 32'h0, 1'b0, 1'b1, 32'd0, 32'd9, 2, 2,
                  {5'd0, 5'd0, 5'd1, 5'd0}, {32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, zs2, ze);
    vecs[8] = mkv(1, 1'b1, 32'h0, 1'b1, 1'b1, 32'd0, 32'd9, 2, 1,
                  20'd0, {32'd0, 32'd0, 32'd0, 32'd9}, zs1, ze);

    rst = 1'b1; req_valid = 1'b0; req_vl = '0; req_div_type = 1'b0; req_is_signed = 1'b0;
    req_vm = 1'b1; kill = 1'b0; busy_force = 1'b0; du_lat = 2;
    cur_vs1 = 32'd1; cur_base = 32'd0; cur_mask = 32'd0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_start_div", 64'(du.start_div), 64'd0);
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_exception", 64'(exception), 64'd0);
    check("rst_div_vs1", 64'(du.div_vs1), 64'd0);
    check("rst_wb_data", 64'(wb_data), 64'd0);
    rst = 1'b0;

    for (int k = 0; k < NV; k++) run_vec(k);

    // vl==0 right after the divide-by-zero ops: done next cycle, exception cleared on accept.
    @(negedge clk);
    d0 = n_done;
    start_req(0, 1'b1, 1'b0, 1'b0);
    @(negedge clk); #1;
    req_valid = 1'b0;
    check("vl0_done_pulse", 64'(done), 64'd1);
    check("vl0_ready_low", 64'(req_ready), 64'd0);
    check("vl0_exc_cleared", 64'(exception), 64'd0);
    @(negedge clk); #1;
    check("vl0_done_low", 64'(done), 64'd0);
    check("vl0_ready_back", 64'(req_ready), 64'd1);

    // busy_du held through three ISSUE cycles; operands must stay put until the result.
    cur_vs1 = 32'd5; cur_base = 32'd50; cur_mask = 32'd0; du_lat = 4; busy_force = 1'b1;
    @(negedge clk);
    a = cyc; s0 = n_start; w0 = wb_d_q.size(); d0 = n_done;
    start_req(1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    busy_force = 1'b0;
    t = 0;
    while (n_start == s0 && t < 20) begin @(negedge clk); #1; t++; end
    check("busy_start_seen", 64'(n_start - s0), 64'd1);
    if (n_start > s0) check("busy_start_cycle", 64'(start_c[start_c.size()-1]), 64'(a + 6));
    t = 0;
    while (wb_d_q.size() == w0 && t < 20) begin
      check("busy_vs1_stable", 64'(du.div_vs1), 64'd5);
      check("busy_vs2_stable", 64'(du.div_vs2), 64'd50);
      @(negedge clk); #1; t++;
    end
    check("busy_wb_seen", 64'(wb_d_q.size() - w0), 64'd1);
    if (wb_d_q.size() > w0) check("busy_wb_data", 64'(wb_d_q[w0]), 64'd10);
    wait_done(d0, "busy");

    // kill in WAIT: drain until the unit answers, discard it, no wb/done.
    cur_vs1 = 32'd3; cur_base = 32'd30; du_lat = 6;
    @(negedge clk);
    a = cyc; s0 = n_start; w0 = wb_d_q.size(); d0 = n_done;
    start_req(1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    t = 0;
    while (n_start == s0 && t < 20) begin @(negedge clk); #1; t++; end
    check("kill_start_cycle", 64'(cyc), 64'(a + 3));
    repeat (2) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      check($sformatf("drain_ready_c%0d", c), 64'(req_ready), 64'd0);
      if (c == 3) check("drain_done_du_seen", 64'(du.done_du), 64'd1);
      @(negedge clk);
    end
    #1;
    check("drain_ready_back", 64'(req_ready), 64'd1);
    repeat (3) @(negedge clk);
    #1;
    check("drain_no_wb", 64'(wb_d_q.size() - w0), 64'd0);
    check("drain_no_done", 64'(n_done - d0), 64'd0);

    // kill while stalled in ISSUE: idle next cycle, never issues.
    busy_force = 1'b1; du_lat = 2;
    @(negedge clk);
    s0 = n_start; d0 = n_done; w0 = wb_d_q.size();
    start_req(4, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    kill = 1'b1;
    @(negedge clk); #1;
    kill = 1'b0;
    check("kill_issue_ready", 64'(req_ready), 64'd1);
    busy_force = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("kill_issue_no_start", 64'(n_start - s0), 64'd0);
    check("kill_issue_no_done", 64'(n_done - d0), 64'd0);
    check("kill_issue_no_wb", 64'(wb_d_q.size() - w0), 64'd0);

    // Normal op after the aborted ones must run cleanly.
    run_vec(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
